// File: rtl/shift_pkg.sv
// shift_pkg: shared constants for the operand-2 shifter stage.
package shift_pkg;
    localparam int DATA_W = 32;
    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;
endpackage

// File: rtl/shift_core.sv
// shift_core: combinational ARM-style barrel shifter (LSL/LSR/ASR/ROR/RRX) with carry-out.
module shift_core
    import shift_pkg::*;
(
    input  logic [DATA_W-1:0] x,
    input  logic [1:0]        sh_type,
    input  logic [7:0]        amt,
    input  logic              amt_is_reg,
    input  logic              c,
    output logic [DATA_W-1:0] result,
    output logic              cout
);
    logic [7:0]               n;
    logic                     rrx;
    logic [DATA_W:0]          lsl_w;
    logic [DATA_W:0]          lsr_w;
    logic signed [DATA_W:0]   asr_w;
    logic [2*DATA_W-1:0]      ror_w;
    // The extra bit in each wide shift captures the last bit shifted out
    always_comb begin
        n      = (!amt_is_reg && amt == 8'd0 && (sh_type == SH_LSR || sh_type == SH_ASR)) ? 8'd32 : amt;
        rrx    = !amt_is_reg && amt == 8'd0 && sh_type == SH_ROR;
        lsl_w  = {1'b0, x} << n[4:0];
        lsr_w  = {x, 1'b0} >> n[4:0];
        asr_w  = $signed({x, 1'b0}) >>> n[4:0];
        ror_w  = {x, x} >> n[4:0];
        result = x;
        cout   = c;
        if (rrx) begin
            result = {c, x[DATA_W-1:1]};
            cout   = x[0];
        end else if (n != 8'd0) begin
            case (sh_type)
                SH_LSL: begin
                    result = (n < 8'd32) ? lsl_w[DATA_W-1:0] : '0;
                    cout   = (n < 8'd32) ? lsl_w[DATA_W] : (n == 8'd32) ? x[0] : 1'b0;
                end
                SH_LSR: begin
                    result = (n < 8'd32) ? lsr_w[DATA_W:1] : '0;
                    cout   = (n < 8'd32) ? lsr_w[0] : (n == 8'd32) ? x[DATA_W-1] : 1'b0;
                end
                SH_ASR: begin
                    result = (n < 8'd32) ? asr_w[DATA_W:1] : {DATA_W{x[DATA_W-1]}};
                    cout   = (n < 8'd32) ? asr_w[0] : x[DATA_W-1];
                end
                default: begin
                    result = ror_w[DATA_W-1:0];
                    cout   = ror_w[DATA_W-1];
                end
            endcase
        end
    end
endmodule

// File: rtl/operand_shift_stage.sv
// operand_shift_stage: registered operand-B shifter feeding the ALU, valid/ready handshake.
module operand_shift_stage
    import shift_pkg::*;
#(
    parameter int OP_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [OP_W-1:0]   in_alu_op,
    input  logic              in_c,
    input  logic [1:0]        in_shift_type,
    input  logic              in_amt_is_reg,
    input  logic [4:0]        in_shift_imm,
    input  logic [7:0]        in_shift_reg,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [OP_W-1:0]   out_alu_op,
    output logic              out_c,
    output logic              out_shift_cout
);
    logic              cap;
    logic [DATA_W-1:0] sh_res;
    logic              sh_cout;
    logic              valid_d, valid_q;
    logic [DATA_W-1:0] a_d, a_q, b_d, b_q;
    logic [OP_W-1:0]   op_d, op_q;
    logic              c_d, c_q, cout_d, cout_q;

    shift_core u_core (
        .x          (in_b),
        .sh_type    (in_shift_type),
        .amt        (in_amt_is_reg ? in_shift_reg : {3'b000, in_shift_imm}),
        .amt_is_reg (in_amt_is_reg),
        .c          (in_c),
        .result     (sh_res),
        .cout       (sh_cout)
    );

    assign in_ready = !valid_q || out_ready;
    assign cap      = in_valid && in_ready;

    always_comb begin
        valid_d = flush ? 1'b0 : cap ? 1'b1 : out_ready ? 1'b0 : valid_q;
        a_d     = cap ? in_a : a_q;
        b_d     = cap ? sh_res : b_q;
        op_d    = cap ? in_alu_op : op_q;
        c_d     = cap ? in_c : c_q;
        cout_d  = cap ? sh_cout : cout_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
        end
    end

    assign out_valid      = valid_q;
    assign out_a          = a_q;
    assign out_b          = b_q;
    assign out_alu_op     = op_q;
    assign out_c          = c_q;
    assign out_shift_cout = cout_q;
endmodule

// File: tb/tb_operand_shift_stage.sv
// tb_operand_shift_stage: directed checks of shifter results, handshake, flush and reset.
module tb_operand_shift_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0, in_b = '0;
    logic [3:0]  in_alu_op = '0;
    logic        in_c = 1'b0;
    logic [1:0]  in_shift_type = '0;
    logic        in_amt_is_reg = 1'b0;
    logic [4:0]  in_shift_imm = '0;
    logic [7:0]  in_shift_reg = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_a, out_b;
    logic [3:0]  out_alu_op;
    logic        out_c, out_shift_cout;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    operand_shift_stage #(.OP_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_alu_op(in_alu_op), .in_c(in_c),
        .in_shift_type(in_shift_type), .in_amt_is_reg(in_amt_is_reg),
        .in_shift_imm(in_shift_imm), .in_shift_reg(in_shift_reg),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_alu_op(out_alu_op),
        .out_c(out_c), .out_shift_cout(out_shift_cout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_item(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                            input logic c, input logic [1:0] ty, input logic isreg,
                            input logic [4:0] imm, input logic [7:0] rg);
        in_a = a; in_b = b; in_alu_op = op; in_c = c;
        in_shift_type = ty; in_amt_is_reg = isreg; in_shift_imm = imm; in_shift_reg = rg;
        in_valid = 1'b1;
    endtask

    task automatic send(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, input logic c, input logic [1:0] ty,
                        input logic isreg, input logic [4:0] imm, input logic [7:0] rg,
                        input logic [31:0] exp_b, input logic exp_cout);
        set_item(a, b, op, c, ty, isreg, imm, rg);
        step();
        in_valid = 1'b0;
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".b"}, out_b, exp_b);
        chk({tag, ".cout"}, 32'(out_shift_cout), 32'(exp_cout));
        chk({tag, ".a"}, out_a, a);
        chk({tag, ".op"}, 32'(out_alu_op), 32'(op));
        chk({tag, ".c"}, 32'(out_c), 32'(c));
    endtask

    initial begin
        #2;
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.b", out_b, 32'd0);
        chk("rst.ready", 32'(in_ready), 32'd1);
        step();
        rst_n = 1'b1;
        step();
        chk("idle.valid", 32'(out_valid), 32'd0);

        send("lsl_imm4", 32'hA5A5_0001, 32'h8000_000F, 4'h3, 1'b0, 2'b00, 1'b0, 5'd4, 8'd0, 32'h0000_00F0, 1'b0);
        send("lsr_imm0", 32'h1111_1111, 32'h8000_0001, 4'h5, 1'b0, 2'b01, 1'b0, 5'd0, 8'd0, 32'h0000_0000, 1'b1);
        send("asr_imm0", 32'h2222_2222, 32'h8000_0001, 4'h6, 1'b0, 2'b10, 1'b0, 5'd0, 8'd0, 32'hFFFF_FFFF, 1'b1);
        send("rrx",      32'h3333_3333, 32'h0000_0003, 4'h7, 1'b1, 2'b11, 1'b0, 5'd0, 8'd0, 32'h8000_0001, 1'b1);
        send("lsl_r32",  32'h4, 32'h0000_0001, 4'h1, 1'b0, 2'b00, 1'b1, 5'd7, 8'd32, 32'h0, 1'b1);
        send("lsl_r33",  32'h5, 32'h0000_0001, 4'h2, 1'b1, 2'b00, 1'b1, 5'd7, 8'd33, 32'h0, 1'b0);
        send("ror_r64",  32'h6, 32'h0000_0001, 4'h8, 1'b1, 2'b11, 1'b1, 5'd7, 8'd64, 32'h0000_0001, 1'b0);
        send("reg0",     32'h7, 32'h0000_0001, 4'h9, 1'b1, 2'b01, 1'b1, 5'd7, 8'd0, 32'h0000_0001, 1'b1);
        send("lsr_r4",   32'h8, 32'h0000_00F8, 4'hA, 1'b0, 2'b01, 1'b1, 5'd0, 8'd4, 32'h0000_000F, 1'b1);
        send("asr_r40",  32'h9, 32'h8000_0000, 4'hB, 1'b0, 2'b10, 1'b1, 5'd0, 8'd40, 32'hFFFF_FFFF, 1'b1);
        send("ror_r8",   32'hA, 32'h1234_5678, 4'hC, 1'b1, 2'b11, 1'b1, 5'd0, 8'd8, 32'h7812_3456, 1'b0);
        send("ror_imm4", 32'hB, 32'h0000_000F, 4'hD, 1'b0, 2'b11, 1'b0, 5'd4, 8'd0, 32'hF000_0000, 1'b1);
        send("lsl_imm1", 32'hC, 32'h8000_0001, 4'hE, 1'b0, 2'b00, 1'b0, 5'd1, 8'd0, 32'h0000_0002, 1'b1);
        send("lsr_r31",  32'hD, 32'h8000_0000, 4'hF, 1'b0, 2'b01, 1'b1, 5'd0, 8'd31, 32'h0000_0001, 1'b0);
        step();
        chk("drain.valid", 32'(out_valid), 32'd0);

        out_ready = 1'b0;
        set_item(32'h100, 32'h1, 4'h1, 1'b0, 2'b00, 1'b0, 5'd1, 8'd0);
        step();
        chk("stall1.valid", 32'(out_valid), 32'd1);
        chk("stall1.b", out_b, 32'h2);
        chk("stall1.ready", 32'(in_ready), 32'd0);
        set_item(32'h200, 32'h1, 4'h2, 1'b1, 2'b00, 1'b0, 5'd2, 8'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall.valid", 32'(out_valid), 32'd1);
            chk("stall.b", out_b, 32'h2);
            chk("stall.a", out_a, 32'h100);
            chk("stall.op", 32'(out_alu_op), 32'h1);
            chk("stall.ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("release.ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("item2.valid", 32'(out_valid), 32'd1);
        chk("item2.b", out_b, 32'h4);
        chk("item2.a", out_a, 32'h200);
        chk("item2.c", 32'(out_c), 32'd1);
        step();
        chk("item2.gone", 32'(out_valid), 32'd0);

        set_item(32'h300, 32'h3, 4'h3, 1'b0, 2'b00, 1'b0, 5'd1, 8'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush.valid", 32'(out_valid), 32'd0);

        send("pre_rst", 32'h400, 32'h0000_0010, 4'h4, 1'b1, 2'b01, 1'b0, 5'd4, 8'd0, 32'h0000_0001, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.valid", 32'(out_valid), 32'd0);
        chk("arst.b", out_b, 32'd0);
        chk("arst.a", out_a, 32'd0);
        chk("arst.c", 32'(out_c), 32'd0);
        step();
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
